// File: rtl/rate_matrix_stepper.sv
// Iterated N x N rate-matrix stepper: one signed multiply-accumulate per cycle,
// Jacobi-ordered updates, wrap or saturate reduction, XOR hash and sticky overflow.
module rate_matrix_stepper #(
  parameter int N   = 4,
  parameter int DW  = 32,
  parameter int EW  = 5,
  parameter int HW  = 8,
  parameter int SAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [$clog2(N)-1:0]  cfg_row,
  input  logic [$clog2(N)-1:0]  cfg_col,
  input  logic [EW-1:0]         cfg_data,
  input  logic                  start,
  input  logic [7:0]            iters,
  input  logic [N*DW-1:0]       x_in,
  output logic                  busy,
  output logic                  done,
  output logic [N*DW-1:0]       x_out,
  output logic [HW-1:0]         hash,
  output logic                  ovf
);

  localparam int IW = $clog2(N);
  localparam int MW = EW + IW + 1;   // signed matrix entry, wide enough for the diagonal
  localparam int PW = DW + MW;       // signed product
  localparam int AW = PW + IW;       // accumulator holds N products without wrapping
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state_q;
  logic [EW-1:0]        e_q [N][N];
  logic signed [DW-1:0] a_q [N];
  logic signed [DW-1:0] b_q [N];
  logic [IW-1:0]        r_q;
  logic [IW-1:0]        c_q;
  logic [7:0]           cnt_q;
  logic [AW-1:0]        acc_q;

  logic                 cfg_hit;
  logic [EW+IW-1:0]     row_sum;
  logic [MW-1:0]        coef;
  logic [DW-1:0]        a_sel;
  logic [PW-1:0]        a_ext;
  logic [PW-1:0]        c_ext;
  logic [PW-1:0]        prod;
  logic [AW-1:0]        acc_base;
  logic [AW-1:0]        acc_sum;
  logic [AW-DW:0]       acc_top;
  logic                 ovf_now;
  logic [DW-1:0]        red;
  logic [HW-1:0]        hash_next;

  // Rates only change while idle, so every run sees one stable matrix.
  assign cfg_hit = cfg_we && (state_q == S_IDLE) && (cfg_row != cfg_col) &&
                   ({1'b0, cfg_row} < (IW+1)'(N)) && ({1'b0, cfg_col} < (IW+1)'(N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          e_q[r][c] <= '0;
        end
      end
    end else if (cfg_hit) begin
      e_q[cfg_row][cfg_col] <= cfg_data;
    end
  end

  // Diagonal is minus the row's off-diagonal sum, derived from the live store.
  always_comb begin
    row_sum = '0;
    for (int c = 0; c < N; c++) begin
      if (IW'(c) != r_q) begin
        row_sum = row_sum + (EW+IW)'(e_q[r_q][c]);
      end
    end
  end

  always_comb begin
    if (c_q == r_q) begin
      coef = MW'(0) - {1'b0, row_sum};
    end else begin
      coef = {{(IW+1){1'b0}}, e_q[r_q][c_q]};
    end
  end

  // Both operands sign-extended to the product width; the low PW bits are exact.
  always_comb begin
    a_sel    = a_q[c_q];
    a_ext    = {{MW{a_sel[DW-1]}}, a_sel};
    c_ext    = {{DW{coef[MW-1]}}, coef};
    prod     = a_ext * c_ext;
    acc_base = (c_q == '0) ? '0 : acc_q;
    acc_sum  = acc_base + {{IW{prod[PW-1]}}, prod};
  end

  // Out of the signed DW range whenever the bits above the DW sign bit disagree.
  always_comb begin
    acc_top = acc_sum[AW-1:DW-1];
    ovf_now = !((&acc_top) || !(|acc_top));
    if ((SAT != 0) && ovf_now) begin
      red = acc_sum[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      red = acc_sum[DW-1:0];
    end
  end

  always_comb begin
    hash_next = '0;
    for (int i = 0; i < N; i++) begin
      hash_next = hash_next ^ a_q[i][HW-1:0];
    end
  end

  // Handshake: start is sampled only while busy is low; busy rises at the accepting
  // edge and falls at the edge that raises done, which stays high for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      x_out   <= '0;
      hash    <= '0;
      ovf     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              a_q[i] <= x_in[i*DW +: DW];
            end
            cnt_q   <= iters;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            r_q     <= '0;
            c_q     <= '0;
            state_q <= (iters == 8'd0) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_sum;
          if (c_q == LAST) begin
            c_q      <= '0;
            b_q[r_q] <= red;
            if (ovf_now) begin
              ovf <= 1'b1;
            end
            if (r_q == LAST) begin
              // Last row lands straight in A alongside the rows already held in B.
              r_q <= '0;
              for (int i = 0; i < N; i++) begin
                a_q[i] <= (IW'(i) == LAST) ? red : b_q[i];
              end
              cnt_q <= cnt_q - 8'd1;
              if (cnt_q == 8'd1) begin
                state_q <= S_FIN;
              end
            end else begin
              r_q <= r_q + 1'b1;
            end
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        S_FIN: begin
          for (int i = 0; i < N; i++) begin
            x_out[i*DW +: DW] <= a_q[i];
          end
          hash    <= hash_next;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rate_matrix_stepper.sv
// Bench for rate_matrix_stepper: wrap and saturate instances share stimulus and are
// checked every cycle against a vector-level model, plus hand-computed scenarios.
module tb_rate_matrix_stepper;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int VW = N * DW;
  localparam longint MAXL = 64'h7fff_ffff_ffff_ffff;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_row = '0;
  logic [1:0]    cfg_col = '0;
  logic [4:0]    cfg_data = '0;
  logic          start = 1'b0;
  logic [7:0]    iters = '0;
  logic [VW-1:0] x_in = '0;

  logic          busy_w, done_w, ovf_w, busy_s, done_s, ovf_s;
  logic [VW-1:0] x_out_w, x_out_s;
  logic [7:0]    hash_w, hash_s;

  always #5 clk = ~clk;

  rate_matrix_stepper #(.N(4), .DW(32), .EW(5), .HW(8), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_data(cfg_data), .start(start), .iters(iters), .x_in(x_in),
    .busy(busy_w), .done(done_w), .x_out(x_out_w), .hash(hash_w), .ovf(ovf_w)
  );

  rate_matrix_stepper #(.N(4), .DW(32), .EW(5), .HW(8), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_data(cfg_data), .start(start), .iters(iters), .x_in(x_in),
    .busy(busy_s), .done(done_s), .x_out(x_out_s), .hash(hash_s), .ovf(ovf_s)
  );

  // ---------------- scoreboard state ----------------
  int            tests = 0;
  int            fails = 0;
  longint        cyc = 0;
  int            e_m [N][N];
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  longint        m_end = 0;
  logic [VW-1:0] m_x [2];
  logic [VW-1:0] m_res [2];
  longint        m_ovf_at [2];

  int            done_total = 0;
  longint        done_cyc = 0;
  int            pin_req = 0;
  int            pin_snap = 0;
  longint        last_s = 0;
  logic [VW-1:0] pin_x = '0;

  logic [VW-1:0] res1 = {-32'sd60, -32'sd20, 32'sd20, 32'sd60};
  logic [VW-1:0] res2 = {32'sd240, 32'sd80, -32'sd80, -32'sd240};
  logic [VW-1:0] x1   = {32'sd40, 32'sd30, 32'sd20, 32'sd10};

  function automatic logic [7:0] hx(input logic [VW-1:0] v);
    logic [7:0] h;
    h = '0;
    for (int i = 0; i < N; i++) h = h ^ v[i*DW +: 8];
    return h;
  endfunction

  // Applies the rate matrix k times to x; records the result and first overflow edge.
  function automatic void compute(input int mode, input int k, input logic [VW-1:0] x,
                                  input longint t0);
    longint v [N];
    longint nv [N];
    longint acc;
    longint d;
    m_ovf_at[mode] = MAXL;
    for (int i = 0; i < N; i++) v[i] = longint'($signed(x[i*DW +: DW]));
    for (int j = 0; j < k; j++) begin
      for (int r = 0; r < N; r++) begin
        d = 0;
        for (int c = 0; c < N; c++) if (c != r) d = d + longint'(e_m[r][c]);
        acc = 0;
        for (int c = 0; c < N; c++) acc = acc + v[c] * ((c == r) ? -d : longint'(e_m[r][c]));
        if (acc > SMAX || acc < SMIN) begin
          if (m_ovf_at[mode] == MAXL) m_ovf_at[mode] = t0 + longint'(j*N*N + (r+1)*N);
          if (mode == 1) nv[r] = (acc > 0) ? SMAX : SMIN;
          else nv[r] = longint'($signed(acc[31:0]));
        end else begin
          nv[r] = acc;
        end
      end
      for (int i = 0; i < N; i++) v[i] = nv[i];
    end
    for (int i = 0; i < N; i++) m_res[mode][i*DW +: DW] = v[i][DW-1:0];
  endfunction

  // Model: tracks what the outputs must be after each clock edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_end  = 0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) e_m[r][c] = 0;
        for (int m = 0; m < 2; m++) begin
          m_x[m] = '0;
          m_res[m] = '0;
          m_ovf_at[m] = MAXL;
        end
      end else begin
        cyc++;
        m_done = 1'b0;
        if (!m_busy) begin
          if (cfg_we && cfg_row != cfg_col) e_m[cfg_row][cfg_col] = int'(cfg_data);
          if (start) begin
            m_busy = 1'b1;
            m_end  = cyc + longint'(iters) * N * N + 1;
            compute(0, int'(iters), x_in, cyc);
            compute(1, int'(iters), x_in, cyc);
          end
        end else if (cyc == m_end) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_x[0] = m_res[0];
          m_x[1] = m_res[1];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic do_pin(input int id);
    case (id)
      1: begin
        chk("rst_busy", VW'(busy_w), '0);
        chk("rst_done", VW'(done_w), '0);
        chk("rst_x_out", x_out_w, '0);
        chk("rst_hash", VW'(hash_w), '0);
        chk("rst_ovf", VW'(ovf_w), '0);
        chk("rst_x_out_sat", x_out_s, '0);
      end
      2: chk("zero_rate_x", x_out_w, '0);
      3: begin
        chk("ones_x", x_out_w, res1);
        chk("ones_hash", VW'(hash_w), '0);
        chk("ones_ovf", VW'(ovf_w), '0);
        chk("ones_done_edge", VW'(done_cyc - last_s), VW'(17));
        chk("ones_done_cnt", VW'(done_total - pin_snap), VW'(1));
      end
      4: begin
        chk("ones2_x", x_out_w, res2);
        chk("ones2_done_edge", VW'(done_cyc - last_s), VW'(33));
      end
      5: begin
        chk("ignored_x", x_out_w, res1);
        chk("ignored_done_cnt", VW'(done_total - pin_snap), VW'(1));
      end
      6: begin
        chk("sat_x1", VW'(x_out_s[63:32]), VW'(32'h7fff_ffff));
        chk("sat_x0", VW'(x_out_s[31:0]), '0);
        chk("sat_ovf", VW'(ovf_s), VW'(1));
        chk("wrap_x1", VW'(x_out_w[63:32]), VW'(32'h7fff_fe10));
        chk("wrap_ovf", VW'(ovf_w), VW'(1));
      end
      7: begin
        chk("abort_x_out", x_out_w, '0);
        chk("abort_busy", VW'(busy_w), '0);
        chk("abort_ovf", VW'(ovf_w), '0);
        chk("abort_hash", VW'(hash_w), '0);
        chk("abort_done_cnt", VW'(done_total - pin_snap), '0);
      end
      8: begin
        chk("iters0_x", x_out_w, pin_x);
        chk("iters0_done_edge", VW'(done_cyc - last_s), VW'(1));
      end
      9: chk("cleared_rates_x", x_out_w, '0);
      default: ;
    endcase
  endtask

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (done_w) begin
        done_total++;
        done_cyc = cyc;
      end
      chk("busy_w", VW'(busy_w), VW'(m_busy));
      chk("done_w", VW'(done_w), VW'(m_done));
      chk("x_out_w", x_out_w, m_x[0]);
      chk("hash_w", VW'(hash_w), VW'(hx(m_x[0])));
      chk("ovf_w", VW'(ovf_w), VW'(cyc >= m_ovf_at[0]));
      chk("busy_s", VW'(busy_s), VW'(m_busy));
      chk("done_s", VW'(done_s), VW'(m_done));
      chk("x_out_s", x_out_s, m_x[1]);
      chk("hash_s", VW'(hash_s), VW'(hx(m_x[1])));
      chk("ovf_s", VW'(ovf_s), VW'(cyc >= m_ovf_at[1]));
      if (pin_req != 0) do_pin(pin_req);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pin(input int id);
    pin_req = id;
    @(negedge clk);
    pin_req = 0;
  endtask

  task automatic cfg_write(input int r, input int c, input int d);
    cfg_we   = 1'b1;
    cfg_row  = 2'(r);
    cfg_col  = 2'(c);
    cfg_data = 5'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_all(input int d);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (r != c) cfg_write(r, c, d);
  endtask

  function automatic logic [VW-1:0] rand_x();
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1) v[i*DW +: DW] = 32'($urandom_range(0, 400)) - 32'd200;
      else v[i*DW +: DW] = $urandom;
    end
    return v;
  endfunction

  // One run; noisy drives rejected writes/starts while busy. Ends with done visible.
  task automatic do_run(input int k, input logic [VW-1:0] x, input bit noisy);
    start  = 1'b1;
    iters  = 8'(k);
    x_in   = x;
    last_s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= k * N * N; j++) begin
      if (noisy) begin
        cfg_we   = 1'($urandom_range(0, 1));
        cfg_row  = 2'($urandom_range(0, 3));
        cfg_col  = 2'($urandom_range(0, 3));
        cfg_data = 5'($urandom_range(0, 31));
        start    = 1'($urandom_range(0, 1));
        iters    = 8'($urandom_range(0, 3));
        x_in     = rand_x();
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
    start  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      cfg_we   = 1'($urandom_range(0, 1));
      cfg_row  = 2'($urandom_range(0, 3));
      cfg_col  = 2'($urandom_range(0, 3));
      cfg_data = 5'($urandom_range(0, 31));
      start    = 1'($urandom_range(0, 1));
      iters    = 8'($urandom_range(0, 255));
      x_in     = rand_x();
    end
    pin(1);
    cfg_we = 1'b0;
    start  = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    do_run(1, rand_x(), 1'b0);
    pin(2);

    set_all(1);
    pin_snap = done_total;
    do_run(1, x1, 1'b0);
    pin(3);
    do_run(2, x1, 1'b0);
    pin(4);

    cfg_write(2, 2, 31);
    pin_snap = done_total;
    do_run(1, x1, 1'b1);
    pin(5);

    set_all(0);
    cfg_write(1, 0, 31);
    do_run(1, {32'd0, 32'd0, 32'd0, 32'h7fff_fff0}, 1'b0);
    pin(6);

    set_all(1);
    pin_snap = done_total;
    start  = 1'b1;
    iters  = 8'd1;
    x_in   = x1;
    last_s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    pin(7);

    pin_x = rand_x();
    do_run(0, pin_x, 1'b0);
    pin(8);
    do_run(1, x1, 1'b0);
    pin(9);

    repeat (30) begin
      repeat ($urandom_range(0, 5))
        cfg_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31));
      do_run($urandom_range(0, 3), rand_x(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
